// File: rtl/adc_spi_captura.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_captura
// Brief    : SPI capture front end for a 12-bit ADCS7476-style ADC. Each
//            request produces one 16-clock frame; the raw sample is presented
//            on dato with a one-cycle dato_valid strobe.
//            Optional macro ADC_ZERO_CHECK_EN checks the leading zero bits
//            and raises frame_err instead of dato_valid when any is set.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_captura #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 12,
    parameter int LEAD_BITS = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] dato,
    output logic                 dato_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int c_fb = LEAD_BITS + DATA_BITS;
    localparam int c_hw = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bw = $clog2(c_fb + 1);
    localparam int c_qw = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    localparam logic [c_hw-1:0] c_hmax  = c_hw'(CLK_DIV - 1);
    localparam logic [c_bw-1:0] c_blast = c_bw'(c_fb - 1);
    localparam logic [c_qw-1:0] c_qmax  = c_qw'(QUIET_CYC - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_conv  = 2'd1;
    localparam logic [1:0] c_st_quiet = 2'd2;

    logic [1:0]           r_state, w_state;
    logic [c_hw-1:0]      r_hcnt,  w_hcnt;
    logic [c_bw-1:0]      r_bcnt,  w_bcnt;
    logic [c_qw-1:0]      r_qcnt,  w_qcnt;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_dato,  w_dato;
    logic                 r_cs_n,  w_cs_n;
    logic                 r_sclk,  w_sclk;
    logic                 r_valid, w_valid;
    logic                 r_ferr,  w_ferr;
`ifdef ADC_ZERO_CHECK_EN
    localparam logic [c_bw-1:0] c_lead = c_bw'(LEAD_BITS);
    logic                 r_lead_err, w_lead_err;
`endif

    always_comb begin
        w_state = r_state;
        w_hcnt  = r_hcnt;
        w_bcnt  = r_bcnt;
        w_qcnt  = r_qcnt;
        w_shift = r_shift;
        w_dato  = r_dato;
        w_cs_n  = r_cs_n;
        w_sclk  = r_sclk;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
`ifdef ADC_ZERO_CHECK_EN
        w_lead_err = r_lead_err;
`endif
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state = c_st_conv;
                    w_cs_n  = 1'b0;
                    w_sclk  = 1'b1;
                    w_hcnt  = '0;
                    w_bcnt  = '0;
`ifdef ADC_ZERO_CHECK_EN
                    w_lead_err = 1'b0;
`endif
                end
            end
            c_st_conv: begin
                if (r_hcnt == c_hmax) begin
                    w_hcnt = '0;
                    w_sclk = ~r_sclk;
                    // sclk 0->1 on this edge: the ADC's bit has been stable since the falling edge
                    if (!r_sclk) begin
                        w_shift = {r_shift[DATA_BITS-2:0], sdata};
                        w_bcnt  = r_bcnt + 1'b1;
`ifdef ADC_ZERO_CHECK_EN
                        if (r_bcnt < c_lead) begin
                            w_lead_err = r_lead_err | sdata;
                        end
`endif
                        if (r_bcnt == c_blast) begin
                            w_state = c_st_quiet;
                            w_cs_n  = 1'b1;
                            w_qcnt  = '0;
`ifdef ADC_ZERO_CHECK_EN
                            if (w_lead_err) begin
                                w_ferr = 1'b1;
                            end else begin
                                w_dato  = w_shift;
                                w_valid = 1'b1;
                            end
`else
                            w_dato  = w_shift;
                            w_valid = 1'b1;
`endif
                        end
                    end
                end else begin
                    w_hcnt = r_hcnt + 1'b1;
                end
            end
            c_st_quiet: begin
                if (r_qcnt == c_qmax) begin
                    w_state = c_st_idle;
                end else begin
                    w_qcnt = r_qcnt + 1'b1;
                end
            end
            default: begin
                w_state = c_st_idle;
                w_cs_n  = 1'b1;
                w_sclk  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_qcnt  <= '0;
            r_shift <= '0;
            r_dato  <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef ADC_ZERO_CHECK_EN
            r_lead_err <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_hcnt  <= w_hcnt;
            r_bcnt  <= w_bcnt;
            r_qcnt  <= w_qcnt;
            r_shift <= w_shift;
            r_dato  <= w_dato;
            r_cs_n  <= w_cs_n;
            r_sclk  <= w_sclk;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
`ifdef ADC_ZERO_CHECK_EN
            r_lead_err <= w_lead_err;
`endif
        end
    end

    assign cs_n       = r_cs_n;
    assign sclk       = r_sclk;
    assign dato       = r_dato;
    assign dato_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_captura.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_captura
// Brief    : Directed/random bench for adc_spi_captura with an ADC frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_captura;

    localparam int D  = 4;
    localparam int FB = 16;
    localparam int Q  = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sdata;
    logic        cs_n;
    logic        sclk;
    logic [11:0] dato;
    logic        dato_valid;
    logic        busy;
    logic        frame_err;

    int n_cmp;
    int n_bad;
    int cyc;
    int n_valid;
    int n_err;
    int n_low;
    int n_rise;
    int n_frames;
    int n_misalign;
    int fall_cyc [8];
    logic prev_cs;
    logic prev_sclk;

    logic [15:0] adc_frame;
    int          adc_idx;
    logic [11:0] ref_dato;

    adc_spi_captura #(
        .CLK_DIV  (D),
        .DATA_BITS(12),
        .LEAD_BITS(4),
        .QUIET_CYC(Q)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sdata     (sdata),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .dato      (dato),
        .dato_valid(dato_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC: the nth falling sclk edge of a frame presents frame bit 16-n
    initial begin
        sdata   = 1'b0;
        adc_idx = 0;
        forever begin
            @(negedge cs_n or negedge sclk);
            if (sclk) begin
                adc_idx = FB;
                sdata   = 1'b0;
            end else if (!cs_n && adc_idx > 0) begin
                adc_idx = adc_idx - 1;
                sdata   = adc_frame[adc_idx];
            end
        end
    end

    initial begin
        prev_cs   = 1'b1;
        prev_sclk = 1'b1;
        cyc       = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (dato_valid) n_valid = n_valid + 1;
            if (frame_err) n_err = n_err + 1;
            if (!cs_n) n_low = n_low + 1;
            if (sclk && !prev_sclk) n_rise = n_rise + 1;
            if (prev_cs && !cs_n) begin
                if (n_frames < 8) fall_cyc[n_frames] = cyc;
                n_frames = n_frames + 1;
            end
            if ((dato_valid || frame_err) && !(cs_n && !prev_cs)) n_misalign = n_misalign + 1;
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_valid    = 0;
        n_err      = 0;
        n_low      = 0;
        n_rise     = 0;
        n_frames   = 0;
        n_misalign = 0;
    endtask

    function automatic logic [24:0] downstream(input logic [11:0] d);
        logic signed [11:0] s;
        s = {~d[11], d[10:0]};
        return {{11{s[11]}}, s, 2'b00};
    endfunction

    // Reference: what one completed frame must leave behind
    task automatic expect_frame(input string tag, input logic [15:0] frm);
        bit lead_bad;
        bit err;
        lead_bad = (frm[15:12] != 4'h0);
`ifdef ADC_ZERO_CHECK_EN
        err = lead_bad;
`else
        err = 1'b0;
`endif
        if (!err) ref_dato = frm[11:0];
        chk({tag, "_frames"}, n_frames, 1);
        chk({tag, "_cs_low"}, n_low, 2 * FB * D);
        chk({tag, "_rises"}, n_rise, FB);
        chk({tag, "_valid"}, n_valid, err ? 0 : 1);
        chk({tag, "_ferr"}, n_err, err ? 1 : 0);
        chk({tag, "_align"}, n_misalign, 0);
        chk({tag, "_dato"}, dato, ref_dato);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] frm, input bit poke);
        int k;
        adc_frame = frm;
        clr();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k = k + 1;
            start = poke && (k == 40 || k == 130);
        end
        start = 1'b0;
        chk({tag, "_busy_off"}, busy, 0);
        repeat (12) @(negedge clk);
        expect_frame(tag, frm);
    endtask

    initial begin
        int k;
        logic [15:0] frm;
        n_cmp     = 0;
        n_bad     = 0;
        ref_dato  = 12'h000;
        adc_frame = 16'h0000;
        clr();

        // reset with start held high: no activity
        rst_n = 1'b0;
        start = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_dato", dato, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", dato_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_quiet", n_low + n_rise, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("a5c", 16'h0A5C, 1'b0);
        run_frame("zero", 16'h0000, 1'b0);
        run_frame("full", 16'h0FFF, 1'b0);
        chk("downstream_fff", downstream(dato), 25'h0001FFC);
        run_frame("poke", {4'h0, 12'($urandom_range(0, 4095))}, 1'b1);
        chk("poke_idle", n_frames, 1);
        for (int i = 0; i < 3; i++) begin
            run_frame("rand", {4'h0, 12'($urandom_range(0, 4095))}, 1'b0);
        end

        // start held high: back-to-back frames
        frm = {4'h0, 12'($urandom_range(0, 4095))};
        adc_frame = frm;
        clr();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (n_frames < 3 && k < 600) begin
            @(negedge clk);
            k = k + 1;
        end
        start = 1'b0;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k = k + 1;
        end
        repeat (12) @(negedge clk);
        chk("b2b_frames", n_frames, 3);
        chk("b2b_period1", fall_cyc[1] - fall_cyc[0], 2 * FB * D + Q + 1);
        chk("b2b_period2", fall_cyc[2] - fall_cyc[1], 2 * FB * D + Q + 1);
        chk("b2b_valid", n_valid, 3);
        chk("b2b_align", n_misalign, 0);
        chk("b2b_dato", dato, frm[11:0]);
        ref_dato = frm[11:0];

        // reset after the 7th rising sclk edge aborts the frame
        adc_frame = 16'h0FFF;
        clr();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (n_rise < 7 && k < 200) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("abort_rise7", n_rise, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 1);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_valid", n_valid, 0);
        chk("abort_dato", dato, 0);
        ref_dato = 12'h000;
        run_frame("after", {4'h0, 12'($urandom_range(0, 4095))}, 1'b0);

        // leading bits not all zero
        run_frame("lead4123", 16'h4123, 1'b0);
        run_frame("leadrnd", {4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_spi_captura.md
Name: adc_spi_captura

Overview:
- Serial capture front end for the 12-bit SPI ADC (ADCS7476/Pmod AD1 style, 16-clock frame: 4 leading zeros, then 12 data bits, MSB first).
- On each sample trigger, generates cs_n/sclk, shifts in one frame and presents the raw straight-binary 12-bit sample with a one-cycle valid strobe.
- Its dato output feeds the downstream MSB-inversion/concatenation stage that builds the 25-bit signed fixed-point word.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half period (≥1); sclk = clk/(2·CLK_DIV).
- DATA_BITS, 12: sample width; equals (cant_bits-3)/2+1 of the consumer (25 → 12).
- LEAD_BITS, 4: leading zero bits per frame; frame length FB = LEAD_BITS+DATA_BITS = 16.
- QUIET_CYC, 8: minimum clk cycles spent in QUIET after cs_n rises.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  conversion request, level-sampled in IDLE only.
- sdata  in  1  ADC serial data.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  ADC serial clock, idles high.
- dato  out  DATA_BITS  last captured sample, raw straight binary, unmodified.
- dato_valid  out  1  one-clk strobe: dato updated.
- busy  out  1  high outside IDLE.
- frame_err  out  1  leading-bit error strobe (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE, cs_n=1, sclk=1, dato=0, dato_valid=0, busy=0, frame_err=0, counters and shift register cleared. Reset mid-frame aborts immediately: cs_n and sclk high, no strobe.
- FSM states:
  - IDLE: start=1 at edge t0 → CONV.
  - CONV: after FB rising sclk edges → QUIET.
  - QUIET: after QUIET_CYC clks → IDLE.
  - start is ignored in CONV and QUIET; there is no queueing.
- Timing, with start sampled at edge t0 and D=CLK_DIV:
  - cs_n=0 from t0 to t0+FB·2D, i.e. low for exactly 32·D clks at defaults.
  - sclk=1 until t0+D, then toggles every D clks.
  - nth rising edge is at t0+2nD, n=1..FB.
- Sampling:
  - sdata is captured at the clk edge where sclk goes 0→1. The ADC changed data on the prior falling edge, so sdata is stable.
  - No synchronizer on sdata.
- Frame end, at edge t0+2·FB·D:
  - last bit shifted in, cs_n←1, sclk stays 1.
  - dato←last DATA_BITS bits received, MSB first.
  - dato_valid←1 for exactly one clk; state←QUIET.
  - Leading LEAD_BITS bits are discarded.
- dato holds its value between strobes. dato_valid is never asserted for aborted frames.
- busy=1 from the cycle after t0 through the last QUIET cycle.
- With start held high, back-to-back frames repeat with cs_n period 2·FB·D+QUIET_CYC+1 clks (137 at defaults). cs_n is high ≥QUIET_CYC+1 clks between frames.
- Counters: the half-period counter counts 0..D-1 and wraps. The bit counter counts 0..FB and saturates at FB with no wrap into a new frame.

Optional Feature:
- Macro ADC_ZERO_CHECK_EN.
- Defined: the LEAD_BITS leading bits are checked. If any is 1, then at frame end:
  - frame_err pulses for one clk instead of dato_valid;
  - dato keeps its previous value;
  - cs_n and QUIET timing are unchanged.
- Undefined: leading bits are ignored and frame_err is tied 0. The port is always present.

Test Plan:
- Reset: rst_n=0 with start=1 → cs_n=1, sclk=1, dato=0, busy=0, dato_valid=0. No activity until rst_n=1.
- Single frame, D=4, ADC model drives 0000_1010_0101_1100 → cs_n low exactly 128 clks, 16 sclk rising edges, dato=12'hA5C, dato_valid one pulse on the same clk cs_n rises.
- Extremes: frames carrying 12'h000 then 12'hFFF → dato=000 then FFF, one strobe each. Downstream stage output checked for 12'hFFF: 25'h0001FFC with MSB inverted, i.e. dato[11] inverted.
- start pulsed mid-CONV and mid-QUIET → ignored, single frame. start held high → cs_n falling edges exactly 137 clks apart, one strobe per frame.
- rst_n asserted after the 7th rising sclk edge → cs_n=1 and sclk=1 immediately, no dato_valid. A subsequent start yields a correct full frame.
- ADC_ZERO_CHECK_EN defined, leading bits 0100, data 12'h123 → frame_err one pulse, no dato_valid, dato unchanged. Macro undefined, same stimulus → dato=12'h123, frame_err=0.
